// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences the shared memory/ALU datapath one state per cycle.
// Optional single-step hold between instructions is built when STEP_EN is defined.
module multicycle_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
`ifdef STEP_EN
    input  logic       change,
    input  logic       step,
`endif
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [5:0] alu_ctrl,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int unsigned ST_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] ALU_ADD  = 6'h20;
    localparam logic [5:0] ALU_SUB  = 6'h22;

    typedef enum logic [ST_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12,
        S_HOLD      = 4'd13
    } state_t;

    state_t     r_state;
    state_t     w_next;
    state_t     w_done_next;
    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_taken;
    logic [1:0] w_pc_src;
    logic       w_ir_write;
    logic       w_i_or_d;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [5:0] w_alu_ctrl;
    logic       w_instr_done;

`ifdef STEP_EN
    logic r_step_meta;
    logic r_step_sync;
    logic r_step_prev;
    logic w_step_rise;

    // Two-flop synchronizer plus rising-edge detect for the step button
    always_ff @(posedge clock) begin
        if (reset) begin
            r_step_meta <= 1'b0;
            r_step_sync <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            r_step_meta <= step;
            r_step_sync <= r_step_meta;
            r_step_prev <= r_step_sync;
        end
    end

    assign w_step_rise = r_step_sync & ~r_step_prev;
    assign w_done_next = change ? S_HOLD : S_FETCH;
`else
    assign w_done_next = S_FETCH;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_taken = (opcode == OP_BNE) ? ~zero : zero;

    // Next-state and per-state datapath controls
    always_comb begin
        w_next          = r_state;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_pc_src        = 2'b00;
        w_ir_write      = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_ctrl      = ALU_ADD;
        w_instr_done    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_ir_write  = 1'b1;
                w_alu_src_b = 2'b01;
                w_pc_write  = 1'b1;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:   w_next = S_MEM_ADDR;
                    OP_RTYPE:       w_next = S_EXECUTE;
                    OP_ADDI:        w_next = S_ADDI_EXEC;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_J:           w_next = S_JUMP;
                    default:        w_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
                w_next     = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = w_done_next;
            end
            S_MEM_WRITE: begin
                w_mem_write  = 1'b1;
                w_i_or_d     = 1'b1;
                w_instr_done = 1'b1;
                w_next       = w_done_next;
            end
            S_EXECUTE: begin
                w_alu_src_a = 1'b1;
                w_alu_ctrl  = funct;
                w_next      = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_reg_dst    = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = w_done_next;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_ctrl      = ALU_SUB;
                w_pc_src        = 2'b01;
                w_pc_write_cond = 1'b1;
                w_instr_done    = 1'b1;
                w_next          = w_done_next;
            end
            S_JUMP: begin
                w_pc_src     = 2'b10;
                w_pc_write   = 1'b1;
                w_instr_done = 1'b1;
                w_next       = w_done_next;
            end
            S_ADDI_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_next      = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = w_done_next;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            S_HOLD: begin
`ifdef STEP_EN
                if (!change || w_step_rise) begin
                    w_next = S_FETCH;
                end
`else
                w_next = S_FETCH;
`endif
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Write strobes and status are suppressed while reset is held
    assign pc_en      = ~reset & (w_pc_write | (w_pc_write_cond & w_taken));
    assign ir_write   = ~reset & w_ir_write;
    assign mem_read   = ~reset & w_mem_read;
    assign mem_write  = ~reset & w_mem_write;
    assign reg_write  = ~reset & w_reg_write;
    assign instr_done = ~reset & w_instr_done;
    assign illegal    = ~reset & (r_state == S_TRAP);
    assign state      = reset ? ST_W'(0) : r_state;
    assign pc_src     = w_pc_src;
    assign i_or_d     = w_i_or_d;
    assign reg_dst    = w_reg_dst;
    assign mem_to_reg = w_mem_to_reg;
    assign alu_src_a  = w_alu_src_a;
    assign alu_src_b  = w_alu_src_b;
    assign alu_ctrl   = w_alu_ctrl;

endmodule
